sar_scan_sequencer: RTL and testbench
=====================================

Name: sar_scan_sequencer

Overview:
Round-robin scan controller that shares the single SAR converter between up to NCH analog channels.
- Per channel: drives the analog mux select, waits a settling delay, pulses SAR start, waits for end-of-conversion, then presents the 8-bit result tagged with its channel.
- Sits between the SAR block and downstream consumers. Replaces the free-running start regenerator for multi-channel use.

Parameters:
NCH, 4, number of analog channels (2..8)
CH_W, 2, width of the channel index (clog2 of NCH)
SETTLE, 3, clk_in cycles the mux is held before start (1..15)
TIMEOUT, 32, clk_in cycles allowed for eoc after start before the channel is abandoned

Ports:
clk_in  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  level; while high, scans repeat back-to-back
chan_mask  in  NCH  bit i=1 includes channel i; sampled at scan start
sar_eoc  in  1  end-of-conversion from SAR
sar_result  in  8  SAR result, valid when sar_eoc rises
sar_start  out  1  one-cycle start pulse to SAR
mux_sel  out  CH_W  analog mux channel select
data_out  out  8  captured conversion result
data_chan  out  CH_W  channel of data_out
data_valid  out  1  one-cycle pulse, data_out/data_chan new
scan_done  out  1  one-cycle pulse after the last masked channel
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky; set on eoc timeout, cleared by reset only

Behaviour:
- Reset (sync, active-high, dominates everything):
  - State is IDLE.
  - All outputs are 0: sar_start, mux_sel, data_out, data_chan, data_valid, scan_done, busy, timeout_err.
  - Internal counters and the eoc history register are 0.
- Reset mid-conversion: the SAR is left alone. The sequencer restarts from IDLE; any eoc rise arriving later is ignored.
- eoc edge: eoc_q is a registered copy of sar_eoc. An eoc edge is sar_eoc=1 with eoc_q=0. A level-high eoc is never treated as a new completion.
- FSM states:
  - IDLE: if enable=1 and chan_mask!=0, latch the mask into mask_r and go to SELECT on the lowest set channel. If mask=0, stay in IDLE.
  - SELECT: mux_sel=current channel; count SETTLE cycles, then go to START.
  - START: sar_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: on an eoc edge, capture sar_result into data_out and the channel into data_chan, and go to NEXT. If TIMEOUT cycles pass without an edge, set timeout_err and go to NEXT without data_valid.
  - NEXT:
    - Pulse data_valid for one cycle, only if a result was captured.
    - Find the next higher set bit in mask_r. If one exists, go to SELECT.
    - Otherwise pulse scan_done. Then: if enable=1, relatch the mask and go to SELECT; else go to IDLE.
- Latency: start pulse to data_valid is (SAR conversion cycles + 2). First mux_sel change to sar_start is SETTLE+1 cycles.
- enable dropping mid-scan: the current scan finishes through scan_done, then the sequencer goes to IDLE.
- chan_mask changes mid-scan: no effect until the next latch.
- Single-channel mask: that channel is rescanned every pass, and scan_done pulses every conversion.
- Simultaneous events:
  - eoc edge and timeout expiry in the same cycle: the edge wins, the result is captured, no error.
  - data_valid and scan_done can assert in the same cycle (last channel).
- mux_sel is stable from SELECT through WAIT; it changes only on leaving NEXT.

Optional Feature:
Macro: SAR_SCAN_OVERSAMPLE_EN
- Defined:
  - Each channel is converted 4 times: START/WAIT repeats with no re-settle.
  - The four results are summed in a 10-bit accumulator.
  - data_out = accumulator[9:2] (truncated mean); data_valid pulses once per channel.
  - A timeout on any of the 4 conversions abandons the channel.
- Not defined: one conversion per channel as above.

Decomposition:
- Shared package sar_pkg:
  - state enum (IDLE, SELECT, START, WAIT, NEXT)
  - result width constant 8
  - oversample count 4
- Sub-module: sar_chan_pick. Combinational next-set-bit finder: given mask_r and the current index, returns the next index and a found flag. Reused for the lowest-bit search in IDLE.

Test Plan:
- Mask 4'b1111, SAR model with comp=(analog[ch]>result), analogs {10,30,60,200} -> data_valid x4 with (chan,data)=(0,10),(1,30),(2,60),(3,200); scan_done on the 4th.
- Mask 4'b0101, enable held -> repeated channel order 0,2,0,2. mux_sel never 1 or 3. sar_start exactly SETTLE+1 cycles after each mux_sel change.
- SAR eoc forced low after start -> timeout_err=1 after 32 cycles. No data_valid for that channel; the sequencer proceeds to the next channel.
- Reset asserted in WAIT, then eoc rises -> all outputs 0. The late eoc produces no data_valid; the scan restarts at channel 0 once enable is high.
- enable dropped during channel 1 of mask 4'b1111 -> channels 1..3 complete, scan_done pulses, busy=0 next cycle.
- With SAR_SCAN_OVERSAMPLE_EN, model returning 100,101,102,103 -> data_out=101, one data_valid per channel.

Source files
------------

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR scan sequencer
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        NEXT
    } state_t;

    localparam int RES_W    = 8;
    localparam int OS_COUNT = 4;

endpackage

// File: rtl/sar_chan_pick.sv
// rtl/sar_chan_pick.sv - combinational next-set-bit finder over a channel mask
module sar_chan_pick #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] cur,
    input  logic            from_zero,
    output logic [CH_W-1:0] next_ch,
    output logic            found
);

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (from_zero || (i > int'(cur)))) begin
                next_ch = CH_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_scan_sequencer.sv
// rtl/sar_scan_sequencer.sv - round-robin SAR channel scan controller
// Optional 4x oversampling per channel when SAR_SCAN_OVERSAMPLE_EN is defined.
module sar_scan_sequencer
    import sar_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CH_W    = 2,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [NCH-1:0]   chan_mask,
    input  logic             sar_eoc,
    input  logic [RES_W-1:0] sar_result,
    output logic             sar_start,
    output logic [CH_W-1:0]  mux_sel,
    output logic [RES_W-1:0] data_out,
    output logic [CH_W-1:0]  data_chan,
    output logic             data_valid,
    output logic             scan_done,
    output logic             busy,
    output logic             timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, state_nx;
    logic [NCH-1:0]  mask_r;
    logic [CH_W-1:0] cur;
    logic [3:0]      scnt;
    logic [TW-1:0]   tcnt;
    logic            eoc_q;
    logic            eoc_edge;

    logic [CH_W-1:0] nxt_ch, first_ch, sel_ch;
    logic            nxt_found, first_found;
    logic            load_sel, latch_mask, capture, abandon;

`ifdef SAR_SCAN_OVERSAMPLE_EN
    localparam logic [1:0] OS_LAST = 2'(OS_COUNT - 1);
    logic [1:0]       os_cnt;
    logic [RES_W+1:0] acc;
    logic [RES_W+1:0] acc_sum;
    assign acc_sum = acc + {2'b00, sar_result};
`endif

    // A level-high eoc left over from a previous conversion is not a completion.
    assign eoc_edge = sar_eoc & ~eoc_q;

    sar_chan_pick #(.NCH(NCH), .CH_W(CH_W)) u_next (
        .mask      (mask_r),
        .cur       (cur),
        .from_zero (1'b0),
        .next_ch   (nxt_ch),
        .found     (nxt_found)
    );

    sar_chan_pick #(.NCH(NCH), .CH_W(CH_W)) u_first (
        .mask      (chan_mask),
        .cur       ('0),
        .from_zero (1'b1),
        .next_ch   (first_ch),
        .found     (first_found)
    );

    always_comb begin
        state_nx   = state;
        sel_ch     = cur;
        load_sel   = 1'b0;
        latch_mask = 1'b0;
        capture    = 1'b0;
        abandon    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && first_found) begin
                    state_nx   = SELECT;
                    sel_ch     = first_ch;
                    load_sel   = 1'b1;
                    latch_mask = 1'b1;
                end
            end
            SELECT: begin
                if (scnt == 4'(SETTLE - 1)) state_nx = START;
            end
            START: state_nx = WAIT;
            WAIT: begin
                // Edge is checked first so it beats a same-cycle timeout.
                if (eoc_edge) begin
`ifdef SAR_SCAN_OVERSAMPLE_EN
                    if (os_cnt == OS_LAST) begin
                        capture  = 1'b1;
                        state_nx = NEXT;
                    end else begin
                        state_nx = START;
                    end
`else
                    capture  = 1'b1;
                    state_nx = NEXT;
`endif
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    abandon  = 1'b1;
                    state_nx = NEXT;
                end
            end
            NEXT: begin
                if (nxt_found) begin
                    state_nx = SELECT;
                    sel_ch   = nxt_ch;
                    load_sel = 1'b1;
                end else if (enable && first_found) begin
                    state_nx   = SELECT;
                    sel_ch     = first_ch;
                    load_sel   = 1'b1;
                    latch_mask = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= IDLE;
            mask_r      <= '0;
            cur         <= '0;
            scnt        <= '0;
            tcnt        <= '0;
            eoc_q       <= 1'b0;
            sar_start   <= 1'b0;
            mux_sel     <= '0;
            data_out    <= '0;
            data_chan   <= '0;
            data_valid  <= 1'b0;
            scan_done   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef SAR_SCAN_OVERSAMPLE_EN
            os_cnt      <= '0;
            acc         <= '0;
`endif
        end else begin
            state      <= state_nx;
            eoc_q      <= sar_eoc;
            sar_start  <= (state == START);
            data_valid <= capture;
            // Outputs are registered on entry to NEXT so both pulses land in the NEXT cycle.
            scan_done  <= (capture | abandon) & ~nxt_found;
            busy       <= (state_nx != IDLE);
            scnt       <= (state == SELECT) ? scnt + 4'd1 : 4'd0;
            if (state == START) begin
                tcnt <= '0;
            end else if (state == WAIT) begin
                tcnt <= tcnt + TW'(1);
            end
            if (latch_mask) mask_r <= chan_mask;
            if (load_sel) begin
                cur     <= sel_ch;
                mux_sel <= sel_ch;
            end
            if (abandon) timeout_err <= 1'b1;
            if (capture) data_chan <= cur;
`ifdef SAR_SCAN_OVERSAMPLE_EN
            if (load_sel) begin
                os_cnt <= '0;
                acc    <= '0;
            end else if (state == WAIT && eoc_edge) begin
                os_cnt <= os_cnt + 2'd1;
                acc    <= acc_sum;
            end
            if (capture) data_out <= acc_sum[RES_W+1:2];
`else
            if (capture) data_out <= sar_result;
`endif
        end
    end

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb/tb_sar_scan_sequencer.sv - directed self-checking bench for sar_scan_sequencer
module tb_sar_scan_sequencer;

    localparam int NCH     = 4;
    localparam int CH_W    = 2;
    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 32;
    localparam int CONV    = 8;

    logic            clk_in     = 1'b0;
    logic            reset      = 1'b1;
    logic            enable     = 1'b0;
    logic [NCH-1:0]  chan_mask  = '0;
    logic            sar_eoc    = 1'b0;
    logic [7:0]      sar_result = '0;
    logic            sar_start;
    logic [CH_W-1:0] mux_sel;
    logic [7:0]      data_out;
    logic [CH_W-1:0] data_chan;
    logic            data_valid;
    logic            scan_done;
    logic            busy;
    logic            timeout_err;

    sar_scan_sequencer #(
        .NCH(NCH), .CH_W(CH_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .chan_mask   (chan_mask),
        .sar_eoc     (sar_eoc),
        .sar_result  (sar_result),
        .sar_start   (sar_start),
        .mux_sel     (mux_sel),
        .data_out    (data_out),
        .data_chan   (data_chan),
        .data_valid  (data_valid),
        .scan_done   (scan_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit-serial SAR model: comparator keeps a trial bit when analog >= trial.
    logic [7:0]      analog [NCH] = '{8'd10, 8'd30, 8'd60, 8'd200};
    logic            stuck   = 1'b0;
    logic            os_mode = 1'b0;
    int              os_idx  = 0;
    logic [3:0]      m_cnt   = '0;
    logic [CH_W-1:0] m_ch    = '0;
    logic [7:0]      m_res   = '0;
    logic [7:0]      m_trial;

    always @(posedge clk_in) begin
        if (sar_start) begin
            m_cnt   <= 4'(CONV);
            m_ch    <= mux_sel;
            m_res   <= '0;
            sar_eoc <= 1'b0;
        end else if (m_cnt != 0) begin
            m_trial = m_res | (8'd1 << (m_cnt - 4'd1));
            if (analog[m_ch] < m_trial) m_trial = m_res;
            m_res <= m_trial;
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1 && !stuck) begin
                sar_eoc    <= 1'b1;
                sar_result <= os_mode ? 8'(100 + os_idx) : m_trial;
                if (os_mode) os_idx <= os_idx + 1;
            end
        end
    end

    int              cyc        = 0;
    int              last_start = -100;
    int              n_valid    = 0;
    int              mux_chg    = -1;
    logic [CH_W-1:0] prev_mux   = '0;
    logic            mux_watch  = 1'b0;
    logic            mux_bad    = 1'b0;
    logic            dist_en    = 1'b0;
    int              dist_q[$];

    always @(negedge clk_in) begin
        cyc++;
        if (sar_start) begin
            last_start = cyc;
            if (dist_en && mux_chg >= 0) dist_q.push_back(cyc - mux_chg);
            mux_chg = -1;
        end
        if (mux_sel != prev_mux) begin
            mux_chg  = cyc;
            prev_mux = mux_sel;
        end
        if (data_valid) n_valid++;
        if (mux_watch && (mux_sel == 2'd1 || mux_sel == 2'd3)) mux_bad = 1'b1;
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic wait_valid(input string tag, output logic [CH_W-1:0] ch,
                              output logic [7:0] d, output logic sd);
        ch = '0;
        d  = '0;
        sd = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (data_valid) begin
                ch = data_chan;
                d  = data_out;
                sd = scan_done;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: no data_valid within 300 cycles", tag);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300 && busy; k++) step();
        check({tag, " idle"}, 32'(busy), 0);
    endtask

    task automatic wait_start(input string tag);
        for (int k = 0; k < 100 && !sar_start; k++) step();
        check({tag, " start seen"}, 32'(sar_start), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " sar_start"},   32'(sar_start),   0);
        check({tag, " mux_sel"},     32'(mux_sel),     0);
        check({tag, " data_out"},    32'(data_out),    0);
        check({tag, " data_chan"},   32'(data_chan),   0);
        check({tag, " data_valid"},  32'(data_valid),  0);
        check({tag, " scan_done"},   32'(scan_done),   0);
        check({tag, " busy"},        32'(busy),        0);
        check({tag, " timeout_err"}, 32'(timeout_err), 0);
    endtask

    logic [CH_W-1:0] g_ch;
    logic [7:0]      g_d;
    logic            g_sd;
    int              snap;
    int              s_cyc;
    int              exp_ch [4];
    int              exp_d  [4];

    initial begin
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        step();

        // Full mask, single scan
        chan_mask = 4'b1111;
        enable    = 1'b1;
        step();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid("t1", g_ch, g_d, g_sd);
            check("t1 chan", 32'(g_ch), i);
            check("t1 data", 32'(g_d), 32'(analog[i]));
            check("t1 scan_done", 32'(g_sd), (i == 3) ? 1 : 0);
`ifndef SAR_SCAN_OVERSAMPLE_EN
            check("t1 latency", cyc - last_start, CONV + 2);
`endif
        end
        step();
        check("t1 busy after done", 32'(busy), 0);

        // Sparse mask with enable held
        exp_ch    = '{0, 2, 0, 2};
        exp_d     = '{10, 60, 10, 60};
        chan_mask = 4'b0101;
        mux_watch = 1'b1;
        dist_en   = 1'b1;
        enable    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid("t2", g_ch, g_d, g_sd);
            check("t2 chan", 32'(g_ch), exp_ch[i]);
            check("t2 data", 32'(g_d), exp_d[i]);
            check("t2 scan_done", 32'(g_sd), (i % 2 == 1) ? 1 : 0);
        end
        enable = 1'b0;
        wait_idle("t2");
        mux_watch = 1'b0;
        dist_en   = 1'b0;
        check("t2 mux_bad", 32'(mux_bad), 0);
        check("t2 settle count", dist_q.size(), 4);
        foreach (dist_q[i]) check("t2 mux-to-start", dist_q[i], SETTLE + 1);

        // eoc never arrives on channel 0
        chan_mask = 4'b0011;
        stuck     = 1'b1;
        enable    = 1'b1;
        step();
        enable = 1'b0;
        wait_start("t3");
        s_cyc = cyc;
        snap  = n_valid;
        while (cyc < s_cyc + TIMEOUT - 1) step();
        check("t3 err before expiry", 32'(timeout_err), 0);
        step();
        check("t3 err at expiry", 32'(timeout_err), 1);
        check("t3 no valid for ch0", n_valid - snap, 0);
        stuck = 1'b0;
        wait_valid("t3", g_ch, g_d, g_sd);
        check("t3 next chan", 32'(g_ch), 1);
        check("t3 next data", 32'(g_d), 30);
        check("t3 scan_done", 32'(g_sd), 1);
        wait_idle("t3");
        check("t3 err sticky", 32'(timeout_err), 1);

        // Reset in WAIT, late eoc ignored
        chan_mask = 4'b1111;
        enable    = 1'b1;
        wait_start("t4");
        repeat (3) step();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) step();
        check_zero("t4 reset");
        reset = 1'b0;
        snap  = n_valid;
        repeat (15) step();
        check("t4 late eoc seen", 32'(sar_eoc), 1);
        check("t4 late eoc ignored", n_valid - snap, 0);
        check("t4 still idle", 32'(busy), 0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_valid("t4", g_ch, g_d, g_sd);
        check("t4 restart chan", 32'(g_ch), 0);
        check("t4 restart data", 32'(g_d), 10);
        wait_idle("t4");

        // enable dropped while channel 1 is settling
        enable = 1'b1;
        wait_valid("t5", g_ch, g_d, g_sd);
        check("t5 chan0", 32'(g_ch), 0);
        repeat (2) step();
        enable = 1'b0;
        for (int i = 1; i < 4; i++) begin
            wait_valid("t5", g_ch, g_d, g_sd);
            check("t5 chan", 32'(g_ch), i);
            check("t5 scan_done", 32'(g_sd), (i == 3) ? 1 : 0);
        end
        step();
        check("t5 busy after done", 32'(busy), 0);

        // Single-channel mask rescans with scan_done every conversion
        chan_mask = 4'b0100;
        enable    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_valid("t6", g_ch, g_d, g_sd);
            check("t6 chan", 32'(g_ch), 2);
            check("t6 data", 32'(g_d), 60);
            check("t6 scan_done", 32'(g_sd), 1);
        end
        enable = 1'b0;
        wait_idle("t6");

`ifdef SAR_SCAN_OVERSAMPLE_EN
        os_mode   = 1'b1;
        chan_mask = 4'b0001;
        snap      = n_valid;
        enable    = 1'b1;
        step();
        enable = 1'b0;
        wait_valid("os", g_ch, g_d, g_sd);
        check("os chan", 32'(g_ch), 0);
        check("os mean", 32'(g_d), 101);
        wait_idle("os");
        check("os one valid", n_valid - snap, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
